// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity codes and frame sizing for the UART blocks
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Serial bit periods in one frame: start + data + optional parity + stop(s).
    function automatic int frame_bits(input int width, input int parity, input int stop_bits);
        return 1 + width + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - word strobe in, serial line and busy flag out
interface uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             i_dv;
    logic [WIDTH-1:0] i_data;
    logic             o_tx;
    logic             o_busy;

    modport master (output i_dv, output i_data, input o_tx, input o_busy);
    modport slave  (input i_dv, input i_data, output o_tx, output o_busy);
endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - free-running bit-period counter, tick on the last cycle of each bit
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = (cnt == LAST) && !i_clear;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, stop bit(s)
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      i_reset,
    uart_tx_if.slave  bus
);
    localparam logic [3:0] LAST_DATA  = 4'(WIDTH - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [3:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             par_q, par_d;
    logic             tick;
    logic             baud_clear;

    // The counter is held clear in IDLE so the start bit gets a full period.
    assign baud_clear = (state_q == ST_IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clear (baud_clear),
        .o_tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.i_dv) begin
                    state_d = ST_START;
                    shift_d = bus.i_data;
                    par_d   = (PARITY == PARITY_EVEN) ? ^bus.i_data : ~^bus.i_data;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (HAS_PARITY) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_d[0];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.o_tx   = tx_q;
    assign bus.o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - four parity/stop configurations driven in parallel against a frame model
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       dv;
    logic [7:0] data;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.WIDTH(8)) ifa ();
    uart_tx_if #(.WIDTH(8)) ifb ();
    uart_tx_if #(.WIDTH(8)) ifc ();
    uart_tx_if #(.WIDTH(8)) ifd ();

    assign ifa.i_dv = dv;  assign ifa.i_data = data;
    assign ifb.i_dv = dv;  assign ifb.i_data = data;
    assign ifc.i_dv = dv;  assign ifc.i_data = data;
    assign ifd.i_dv = dv;  assign ifd.i_data = data;

    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut_a (.clk(clk), .i_reset(rst), .bus(ifa));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut_b (.clk(clk), .i_reset(rst), .bus(ifb));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut_c (.clk(clk), .i_reset(rst), .bus(ifc));
    uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut_d (.clk(clk), .i_reset(rst), .bus(ifd));

    function automatic int cfg_par(input int j);
        return (j == 0) ? 0 : (j == 1) ? 1 : 2;
    endfunction

    function automatic int cfg_stop(input int j);
        return (j == 3) ? 2 : 1;
    endfunction

    function automatic int nbits(input int j);
        return 1 + 8 + ((cfg_par(j) != 0) ? 1 : 0) + cfg_stop(j);
    endfunction

    function automatic logic dut_tx(input int j);
        case (j)
            0:       return ifa.o_tx;
            1:       return ifb.o_tx;
            2:       return ifc.o_tx;
            default: return ifd.o_tx;
        endcase
    endfunction

    function automatic logic dut_busy(input int j);
        case (j)
            0:       return ifa.o_busy;
            1:       return ifb.o_busy;
            2:       return ifc.o_busy;
            default: return ifd.o_busy;
        endcase
    endfunction

    // Line level k cycles after acceptance, built from the frame layout.
    function automatic logic exp_tx(input int j, input logic [7:0] d, input int k,
                                    input logic pe, input logic po);
        int bi;
        bi = k / CPB;
        if (bi >= nbits(j)) return 1'b1;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return d[bi-1];
        if (cfg_par(j) != 0 && bi == 9) return (cfg_par(j) == 2) ? pe : po;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_all(input string tag);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s dut%0d tx", tag, j), 32'(dut_tx(j)), 32'd1);
            chk($sformatf("%s dut%0d busy", tag, j), 32'(dut_busy(j)), 32'd0);
        end
    endtask

    // Called just after a negedge; dv is held for dvc accepting edges.
    task automatic check_frame(input logic [7:0] d, input int dvc, input logic pe,
                               input logic po, input string tag);
        int blen[4];
        for (int j = 0; j < 4; j++) blen[j] = 0;
        dv   = 1'b1;
        data = d;
        for (int k = 0; k < 52; k++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("%s dut%0d k=%0d tx", tag, j, k), 32'(dut_tx(j)), 32'(exp_tx(j, d, k, pe, po)));
                chk($sformatf("%s dut%0d k=%0d busy", tag, j, k), 32'(dut_busy(j)), 32'(k < nbits(j) * CPB));
                if (dut_busy(j)) blen[j]++;
            end
            if (k == dvc - 1) dv = 1'b0;
        end
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s dut%0d busy_len", tag, j), 32'(blen[j]), 32'(nbits(j) * CPB));
    endtask

    // Receiver for the no-parity DUT: waits for busy, records the line, decodes at bit centres.
    task automatic rx_frame_a(output logic [7:0] b, output int len, output int gap, output bit fr_ok);
        logic q[$];
        gap   = 0;
        len   = 0;
        b     = '0;
        fr_ok = 1'b0;
        while (!ifa.o_busy && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        if (!ifa.o_busy) return;
        while (ifa.o_busy && len < 200) begin
            q.push_back(ifa.o_tx);
            len++;
            @(negedge clk);
        end
        if (q.size() >= 10 * CPB) begin
            for (int i = 0; i < 8; i++) b[i] = q[(i + 1) * CPB + 1];
            fr_ok = (q[1] == 1'b0) && (q[9 * CPB + 1] == 1'b1);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        int         dvc;
        logic       exp_even;
        logic       exp_odd;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] rb;
        logic [7:0] rd;
        int         rl;
        int         rg;
        bit         rf;
        logic [7:0] fifo_bytes[3];

        vecs[0] = '{8'hA5, 1, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 3, 1'b0, 1'b1};
        vecs[2] = '{8'h07, 1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 2, 1'b0, 1'b1};

        // Reset held with dv high: nothing may start.
        rst  = 1'b1;
        dv   = 1'b1;
        data = 8'h55;
        @(negedge clk);
        chk_idle_all("reset1");
        @(negedge clk);
        chk_idle_all("reset2");
        rst = 1'b0;
        dv  = 1'b0;
        @(negedge clk);
        chk_idle_all("post_reset");

        foreach (vecs[i])
            check_frame(vecs[i].d, vecs[i].dvc, vecs[i].exp_even, vecs[i].exp_odd, $sformatf("vec%0d", i));

        for (int r = 0; r < 6; r++) begin
            rd = 8'($urandom);
            check_frame(rd, int'($urandom_range(1, 3)), ($countones(rd) % 2) == 1,
                        ($countones(rd) % 2) == 0, $sformatf("rand%0d", r));
        end

        // Reset during data bit 3 of 8'hFF.
        dv   = 1'b1;
        data = 8'hFF;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            dv = 1'b0;
        end
        chk("midreset busy_before", 32'(ifa.o_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_all("midreset");
        rst = 1'b0;
        check_frame(8'h00, 1, 1'b0, 1'b1, "after_reset");

        // dv held continuously, data changed mid-frame.
        dv   = 1'b1;
        data = 8'h5A;
        fork
            rx_frame_a(rb, rl, rg, rf);
            begin
                repeat (10) @(negedge clk);
                data = 8'hC3;
            end
        join
        chk("b2b first byte", 32'(rb), 32'h5A);
        chk("b2b first len", 32'(rl), 32'd40);
        chk("b2b first framing", 32'(rf), 32'd1);
        rx_frame_a(rb, rl, rg, rf);
        chk("b2b gap", 32'(rg), 32'd1);
        chk("b2b second byte", 32'(rb), 32'hC3);
        chk("b2b second len", 32'(rl), 32'd40);
        dv = 1'b0;
        repeat (60) @(negedge clk);
        chk_idle_all("b2b_end");

        // Upstream controller emulation: strobe lags busy by one extra cycle.
        fifo_bytes = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            dv   = 1'b1;
            data = fifo_bytes[i];
            fork
                rx_frame_a(rb, rl, rg, rf);
                begin
                    repeat (2) @(negedge clk);
                    dv = 1'b0;
                end
            join
            chk($sformatf("fifo%0d byte", i), 32'(rb), 32'(fifo_bytes[i]));
            chk($sformatf("fifo%0d len", i), 32'(rl), 32'd40);
            chk($sformatf("fifo%0d framing", i), 32'(rf), 32'd1);
        end
        rl = 0;
        repeat (50) begin
            @(negedge clk);
            if (ifa.o_busy) rl++;
        end
        chk("fifo no extra frame", 32'(rl), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
